pc_predict: RTL and testbench

//  Parametrised next-PC generator for the fetch stage; supersedes the fixed 3-way PC source select.

---
 rtl/pc_pkg.sv | 31 +++
 rtl/btb_table.sv | 36 +++
 rtl/pc_predict.sv | 109 ++++++++++
 tb/tb_pc_predict.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch-stage next-PC predictor.
// A BTB entry carries a 2-bit bimodal counter, an unconditional flag, a tag and a target.
package pc_pkg;

  localparam int PC_W = 32;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // Tag is stored zero-extended to PC_W so the entry layout is independent of BTB depth.
  typedef struct packed {
    logic            valid;
    logic            uncond;
    logic [1:0]      ctr;
    logic [PC_W-1:0] tag;
    logic [PC_W-1:0] target;
  } btb_entry_t;

  localparam int ENTRY_W = $bits(btb_entry_t);

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == CTR_ST) ? CTR_ST : c + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == CTR_SNT) ? CTR_SNT : c - 2'd1;
  endfunction

endpackage

// File: rtl/btb_table.sv
// Direct-mapped BTB storage: two async read ports (fetch and execute) and one sync write port.
// Only the valid bits are reset; tag/target/counter are don't-care while invalid.
module btb_table
  import pc_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [IDX_W-1:0]   rd_f_idx_i,
  output logic [ENTRY_W-1:0] rd_f_o,
  input  logic [IDX_W-1:0]   rd_e_idx_i,
  output logic [ENTRY_W-1:0] rd_e_o,
  input  logic               wr_en_i,
  input  logic               clr_en_i,
  input  logic [IDX_W-1:0]   wr_idx_i,
  input  logic [ENTRY_W-1:0] wr_entry_i
);

  btb_entry_t mem_q [ENTRIES];

  assign rd_f_o = mem_q[rd_f_idx_i];
  assign rd_e_o = mem_q[rd_e_idx_i];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) mem_q[i].valid <= 1'b0;
    end else if (clr_en_i) begin
      mem_q[wr_idx_i].valid <= 1'b0;
    end else if (wr_en_i) begin
      mem_q[wr_idx_i] <= btb_entry_t'(wr_entry_i);
    end
  end

endmodule

// File: rtl/pc_predict.sv
// Fetch PC register with BTB-based next-PC prediction and EX-stage outcome resolution.
// Mispredict/RedirectPC are combinational and feed the hazard unit's D/E flush.
module pc_predict
  import pc_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              BTB_ENTRIES = 16,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            StallF,
  output logic [XLEN-1:0] PCF,
  output logic            PredTakenF,
  output logic [XLEN-1:0] PredTargetF,
  input  logic            ResolveE,
  input  logic [XLEN-1:0] PCE,
  input  logic            Jump,
  input  logic            Jumpr,
  input  logic            Branch,
  input  logic            br_taken,
  input  logic [XLEN-1:0] TargetE,
  input  logic [XLEN-1:0] ALUResultE,
  input  logic            PredTakenE,
  input  logic [XLEN-1:0] PredTargetE,
  output logic            Mispredict,
  output logic [XLEN-1:0] RedirectPC
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);

  logic [XLEN-1:0]  pcf_q, pcf_d;
  logic [IDX_W-1:0] idx_f, idx_e;
  logic [PC_W-1:0]  tag_f, tag_e;
  btb_entry_t       ent_f, ent_e, wr_entry;
  logic             hit_f, hit_e, wr_en, clr_en;
  logic             taken_e;
  logic [XLEN-1:0]  actual_e;

  assign idx_f = pcf_q[IDX_W+1:2];
  assign tag_f = PC_W'(pcf_q[XLEN-1:IDX_W+2]);
  assign idx_e = PCE[IDX_W+1:2];
  assign tag_e = PC_W'(PCE[XLEN-1:IDX_W+2]);

  btb_table #(.ENTRIES(BTB_ENTRIES)) u_btb (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_f_idx_i (idx_f),
    .rd_f_o     (ent_f),
    .rd_e_idx_i (idx_e),
    .rd_e_o     (ent_e),
    .wr_en_i    (wr_en),
    .clr_en_i   (clr_en),
    .wr_idx_i   (idx_e),
    .wr_entry_i (wr_entry)
  );

  // Fetch-side lookup sees the table as registered, never the same-cycle update.
  assign hit_f       = ent_f.valid && (ent_f.tag == tag_f);
  assign PredTakenF  = hit_f && (ent_f.uncond || ent_f.ctr[1]);
  assign PredTargetF = XLEN'(ent_f.target);
  assign PCF         = pcf_q;

  assign taken_e    = Jump | Jumpr | (Branch & br_taken);
  assign actual_e   = Jumpr ? (ALUResultE & ~XLEN'(1)) : TargetE;
  assign RedirectPC = taken_e ? actual_e : PCE + XLEN'(4);
  assign Mispredict = rst_n && ResolveE &&
                      ((taken_e != PredTakenE) || (taken_e && (PredTargetE != actual_e)));

  always_comb begin
    pcf_d = pcf_q + XLEN'(4);
    if (Mispredict)      pcf_d = RedirectPC;
    else if (StallF)     pcf_d = pcf_q;
    else if (PredTakenF) pcf_d = PredTargetF;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pcf_q <= RESET_PC;
    else        pcf_q <= pcf_d;
  end

  assign hit_e = ent_e.valid && (ent_e.tag == tag_e);

  // Update policy: jumps always install as strongly taken; branches train or allocate on taken;
  // a non-control instruction that hits is an alias and drops the entry.
  always_comb begin
    wr_en    = 1'b0;
    clr_en   = 1'b0;
    wr_entry = ent_e;
    if (ResolveE) begin
      if (Jump || Jumpr) begin
        wr_en    = 1'b1;
        wr_entry = '{valid: 1'b1, uncond: 1'b1, ctr: CTR_ST, tag: tag_e, target: PC_W'(actual_e)};
      end else if (Branch) begin
        if (hit_e) begin
          wr_en        = 1'b1;
          wr_entry.ctr = br_taken ? sat_inc(ent_e.ctr) : sat_dec(ent_e.ctr);
          if (br_taken) wr_entry.target = PC_W'(actual_e);
        end else if (br_taken) begin
          wr_en    = 1'b1;
          wr_entry = '{valid: 1'b1, uncond: 1'b0, ctr: CTR_WT, tag: tag_e, target: PC_W'(actual_e)};
        end
      end else if (hit_e) begin
        clr_en = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pc_predict.sv
// Self-checking bench for pc_predict: directed scenarios plus randomized traffic
// against an array-based BTB/PC reference model.
module tb_pc_predict;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst_n, StallF, ResolveE, Jump, Jumpr, Branch, br_taken, PredTakenE;
  logic [31:0] PCE, TargetE, ALUResultE, PredTargetE;
  logic [31:0] PCF, PredTargetF, RedirectPC;
  logic        PredTakenF, Mispredict;

  always #5 clk = ~clk;

  pc_predict #(.XLEN(32), .BTB_ENTRIES(N), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .StallF(StallF), .PCF(PCF), .PredTakenF(PredTakenF),
    .PredTargetF(PredTargetF), .ResolveE(ResolveE), .PCE(PCE), .Jump(Jump), .Jumpr(Jumpr),
    .Branch(Branch), .br_taken(br_taken), .TargetE(TargetE), .ALUResultE(ALUResultE),
    .PredTakenE(PredTakenE), .PredTargetE(PredTargetE), .Mispredict(Mispredict),
    .RedirectPC(RedirectPC)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: per-slot arrays, counter as an integer 0..3.
  bit          mv[N];
  bit          mu[N];
  int          mc[N];
  logic [31:0] mtag[N];
  logic [31:0] mtgt[N];
  logic [31:0] mpc;
  logic [31:0] e_pcf, e_ptg, e_red;
  logic        e_pt, e_mis;

  function automatic int midx(input logic [31:0] pc);
    return int'((pc >> 2) % 32'(N));
  endfunction

  function automatic logic [31:0] mtagof(input logic [31:0] pc);
    return pc / 32'(4 * N);
  endfunction

  task automatic mlook(input logic [31:0] pc, output logic t, output logic [31:0] tg);
    int i;
    i  = midx(pc);
    t  = mv[i] && (mtag[i] == mtagof(pc)) && (mu[i] || mc[i] >= 2);
    tg = mtgt[i];
  endtask

  // kind: 0 none, 1 JAL, 2 JALR, 3 branch
  task automatic drive(input bit rs, input bit st, input bit res, input logic [31:0] pce,
                       input int kind, input bit bt, input logic [31:0] tgt,
                       input logic [31:0] alu, input bit ptk, input logic [31:0] ptg);
    logic        tk;
    logic [31:0] act;
    rst_n = rs; StallF = st; ResolveE = res; PCE = pce;
    Jump = (kind == 1); Jumpr = (kind == 2); Branch = (kind == 3); br_taken = bt;
    TargetE = tgt; ALUResultE = alu; PredTakenE = ptk; PredTargetE = ptg;
    e_pcf = mpc;
    mlook(mpc, e_pt, e_ptg);
    tk    = (kind == 1) || (kind == 2) || (kind == 3 && bt);
    act   = (kind == 2) ? {alu[31:1], 1'b0} : tgt;
    e_red = tk ? act : pce + 32'd4;
    e_mis = rs && res && ((tk != ptk) || (tk && ptg != act));
    #2;
  endtask

  task automatic tick();
    logic [31:0] nxt, act;
    int          i;
    bit          hit, tk;
    @(posedge clk);
    if (!rst_n) begin
      mpc = 32'h0;
      for (int k = 0; k < N; k++) mv[k] = 1'b0;
    end else begin
      if (e_mis)       nxt = e_red;
      else if (StallF) nxt = mpc;
      else if (e_pt)   nxt = e_ptg;
      else             nxt = mpc + 32'd4;
      if (ResolveE) begin
        i   = midx(PCE);
        hit = mv[i] && (mtag[i] == mtagof(PCE));
        tk  = Branch && br_taken;
        act = Jumpr ? {ALUResultE[31:1], 1'b0} : TargetE;
        if (Jump || Jumpr) begin
          mv[i] = 1'b1; mu[i] = 1'b1; mc[i] = 3; mtag[i] = mtagof(PCE); mtgt[i] = act;
        end else if (Branch) begin
          if (hit) begin
            mc[i] = tk ? ((mc[i] == 3) ? 3 : mc[i] + 1) : ((mc[i] == 0) ? 0 : mc[i] - 1);
            if (tk) mtgt[i] = act;
          end else if (tk) begin
            mv[i] = 1'b1; mu[i] = 1'b0; mc[i] = 2; mtag[i] = mtagof(PCE); mtgt[i] = act;
          end
        end else if (hit) begin
          mv[i] = 1'b0;
        end
      end
      mpc = nxt;
    end
    #1;
  endtask

  task automatic idle(input bit st);
    drive(1'b1, st, 1'b0, 32'h0, 0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic resolve(input logic [31:0] pce, input int kind, input bit bt,
                         input logic [31:0] tgt, input logic [31:0] alu);
    logic        pk;
    logic [31:0] pg;
    mlook(pce, pk, pg);
    drive(1'b1, 1'b0, 1'b1, pce, kind, bt, tgt, alu, pk, pg);
  endtask

  // Force PCF to addr via an aliased non-control instruction at addr-4.
  task automatic steer(input logic [31:0] addr);
    drive(1'b1, 1'b0, 1'b1, addr - 32'd4, 0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
    tick();
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 1'b1, 32'h40, 0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
    total++; if (Mispredict !== 1'b0) begin bad++; $display("FAIL rst_mispredict got %b want 0", Mispredict); end
    tick();
    for (int k = 0; k < 4; k++) begin
      idle(1'b0);
      total++; if (PCF !== 32'(4 * k)) begin bad++; $display("FAIL rst_seq_pcf got %h want %h", PCF, 32'(4 * k)); end
      total++; if (PredTakenF !== 1'b0) begin bad++; $display("FAIL rst_predtaken got %b want 0", PredTakenF); end
      tick();
    end
  endtask

  task automatic test_loop();
    for (int p = 0; p < 3; p++) begin
      resolve(32'h10, 3, 1'b1, 32'h08, 32'h0);
      total++; if (Mispredict !== (p == 0)) begin bad++; $display("FAIL loop_mis%0d got %b want %b", p, Mispredict, p == 0); end
      total++; if (RedirectPC !== 32'h08) begin bad++; $display("FAIL loop_redirect got %h want 00000008", RedirectPC); end
      tick();
      for (int c = 0; c < 4; c++) begin
        idle(1'b0);
        total++; if (PCF !== e_pcf) begin bad++; $display("FAIL loop_pcf got %h want %h", PCF, e_pcf); end
        total++; if (PredTakenF !== e_pt) begin bad++; $display("FAIL loop_pt got %b want %b", PredTakenF, e_pt); end
        if (p == 0 && c == 2) begin
          total++; if (PCF !== 32'h10 || PredTakenF !== 1'b1 || PredTargetF !== 32'h08) begin
            bad++; $display("FAIL loop_pred pc=%h pt=%b tgt=%h want 10/1/08", PCF, PredTakenF, PredTargetF); end
        end
        tick();
      end
    end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 5; k++) begin
      resolve(32'h44, 3, k < 4, 32'h200, 32'h0);
      total++; if (Mispredict !== (k == 0 || k == 4)) begin bad++; $display("FAIL sat_mis%0d got %b want %b", k, Mispredict, k == 0 || k == 4); end
      tick();
    end
    steer(32'h44); idle(1'b0);
    total++; if (PCF !== 32'h44 || PredTakenF !== 1'b1) begin bad++; $display("FAIL sat_still_taken pc=%h pt=%b want 44/1", PCF, PredTakenF); end
    tick();
    resolve(32'h44, 3, 1'b0, 32'h200, 32'h0);
    total++; if (Mispredict !== 1'b1 || RedirectPC !== 32'h48) begin bad++; $display("FAIL sat_nt2 mis=%b red=%h want 1/48", Mispredict, RedirectPC); end
    tick();
    steer(32'h44); idle(1'b0);
    total++; if (PredTakenF !== 1'b0) begin bad++; $display("FAIL sat_wnt got %b want 0", PredTakenF); end
    tick();
  endtask

  task automatic test_jalr();
    resolve(32'h80, 2, 1'b0, 32'h9999, 32'h1235);
    total++; if (RedirectPC !== 32'h1234 || Mispredict !== 1'b1) begin bad++; $display("FAIL jalr_first red=%h mis=%b want 1234/1", RedirectPC, Mispredict); end
    tick();
    resolve(32'h80, 2, 1'b0, 32'h9999, 32'h2000);
    total++; if (PredTakenE !== 1'b1 || PredTargetE !== 32'h1234) begin bad++; $display("FAIL jalr_model_pred pt=%b tgt=%h want 1/1234", PredTakenE, PredTargetE); end
    total++; if (Mispredict !== 1'b1 || RedirectPC !== 32'h2000) begin bad++; $display("FAIL jalr_tgt_mis mis=%b red=%h want 1/2000", Mispredict, RedirectPC); end
    tick();
  endtask

  task automatic test_alias();
    drive(1'b1, 1'b0, 1'b1, 32'h80, 0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h2000);
    total++; if (Mispredict !== 1'b1 || RedirectPC !== 32'h84) begin bad++; $display("FAIL alias_mis mis=%b red=%h want 1/84", Mispredict, RedirectPC); end
    tick();
    idle(1'b0);
    total++; if (PCF !== 32'h84) begin bad++; $display("FAIL alias_pcf got %h want 84", PCF); end
    tick();
    steer(32'h80); idle(1'b0);
    total++; if (PCF !== 32'h80 || PredTakenF !== 1'b0) begin bad++; $display("FAIL alias_invalid pc=%h pt=%b want 80/0", PCF, PredTakenF); end
    tick();
  endtask

  task automatic test_stall();
    drive(1'b1, 1'b1, 1'b1, 32'h300, 0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
    total++; if (Mispredict !== 1'b1) begin bad++; $display("FAIL stall_mis got %b want 1", Mispredict); end
    tick();
    for (int k = 0; k < 4; k++) begin
      idle(1'b1);
      total++; if (PCF !== 32'h304) begin bad++; $display("FAIL stall_hold%0d got %h want 304", k, PCF); end
      tick();
    end
  endtask

  task automatic test_wrap();
    steer(32'hFFFF_FFFC); idle(1'b0);
    total++; if (PCF !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_top got %h want fffffffc", PCF); end
    tick(); idle(1'b0);
    total++; if (PCF !== 32'h0) begin bad++; $display("FAIL wrap_pcf got %h want 0", PCF); end
    tick();
    drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h10);
    total++; if (RedirectPC !== 32'h0 || Mispredict !== 1'b1) begin bad++; $display("FAIL wrap_redirect red=%h mis=%b want 0/1", RedirectPC, Mispredict); end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] pce, pg;
    logic        pk;
    int          kind;
    for (int n = 0; n < 800; n++) begin
      pce  = 32'($urandom_range(0, 47)) << 2;
      kind = $urandom_range(0, 9);
      kind = (kind < 2) ? 1 : (kind == 2) ? 2 : (kind < 7) ? 3 : 0;
      mlook(pce, pk, pg);
      if ($urandom_range(0, 4) == 0) begin pk = 1'($urandom); pg = 32'($urandom_range(0, 63)) << 2; end
      drive($urandom_range(0, 99) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0, pce,
            kind, 1'($urandom), 32'($urandom_range(0, 63)) << 2, $urandom, pk, pg);
      total++; if (PCF !== e_pcf) begin bad++; $display("FAIL rnd_pcf n=%0d got %h want %h", n, PCF, e_pcf); end
      total++; if (PredTakenF !== e_pt) begin bad++; $display("FAIL rnd_pt n=%0d got %b want %b", n, PredTakenF, e_pt); end
      if (e_pt) begin
        total++; if (PredTargetF !== e_ptg) begin bad++; $display("FAIL rnd_ptgt n=%0d got %h want %h", n, PredTargetF, e_ptg); end
      end
      total++; if (Mispredict !== e_mis) begin bad++; $display("FAIL rnd_mis n=%0d got %b want %b", n, Mispredict, e_mis); end
      total++; if (RedirectPC !== e_red) begin bad++; $display("FAIL rnd_red n=%0d got %h want %h", n, RedirectPC, e_red); end
      tick();
    end
  endtask

  initial begin
    mpc = 32'h0;
    for (int k = 0; k < N; k++) begin mv[k] = 1'b0; mu[k] = 1'b0; mc[k] = 0; mtag[k] = '0; mtgt[k] = '0; end
    test_reset();
    test_loop();
    test_saturation();
    test_jalr();
    test_alias();
    test_stall();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
